// File: rtl/ast_packet_arbiter.sv
// Packet-atomic round-robin arbiter merging N_REQ Avalon-ST sources onto one
// stream; each output beat carries the granted requester index on ast_channel_o.
module ast_packet_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 64,
  parameter int EMPTY_W   = 3,
  parameter int CHANNEL_W = 4
) (
  input  logic                     clk,
  input  logic                     srst_i,
  input  logic [N_REQ*DATA_W-1:0]  ast_data_i,
  input  logic [N_REQ-1:0]         ast_startofpacket_i,
  input  logic [N_REQ-1:0]         ast_endofpacket_i,
  input  logic [N_REQ-1:0]         ast_valid_i,
  input  logic [N_REQ*EMPTY_W-1:0] ast_empty_i,
  output logic [N_REQ-1:0]         ast_ready_o,
  output logic [DATA_W-1:0]        ast_data_o,
  output logic                     ast_startofpacket_o,
  output logic                     ast_endofpacket_o,
  output logic                     ast_valid_o,
  output logic [EMPTY_W-1:0]       ast_empty_o,
  output logic [CHANNEL_W-1:0]     ast_channel_o,
  input  logic                     ast_ready_i
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                          r_state, w_state_nxt;
  logic [GW-1:0]                   r_grant, r_last, w_pick;
  logic                            w_found;
  logic                            w_load, w_accept;

  logic [N_REQ-1:0][DATA_W-1:0]    w_data;
  logic [N_REQ-1:0][EMPTY_W-1:0]   w_empty;
  logic [N_REQ-1:0]                w_elig;

  logic [DATA_W-1:0]               r_data;
  logic                            r_sop, r_eop, r_valid;
  logic [EMPTY_W-1:0]              r_empty;
  logic [CHANNEL_W-1:0]            r_channel;

  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    assign w_data[g]  = ast_data_i[g*DATA_W +: DATA_W];
    assign w_empty[g] = ast_empty_i[g*EMPTY_W +: EMPTY_W];
    // Only a valid start-of-packet beat may win arbitration.
    assign w_elig[g]  = ast_valid_i[g] & ast_startofpacket_i[g];
  end

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_last;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!w_found && w_elig[(int'(r_last) + k) % N_REQ]) begin
        w_found = 1'b1;
        w_pick  = GW'((int'(r_last) + k) % N_REQ);
      end
    end
  end

  assign w_load   = !r_valid || ast_ready_i;
  assign w_accept = (r_state == BUSY) && ast_valid_i[r_grant] && w_load;

  always_comb begin
    ast_ready_o = '0;
    if (r_state == BUSY)
      ast_ready_o[r_grant] = w_load;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_found) w_state_nxt = BUSY;
      BUSY:    if (w_accept && ast_endofpacket_i[r_grant]) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst_i) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= GW'(N_REQ - 1);
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_found) begin
        r_grant <= w_pick;
        r_last  <= w_pick;
      end
    end
  end

  // Single output stage: loads on an accepted beat, otherwise drains when the
  // sink takes the held beat, and holds every field while stalled.
  always_ff @(posedge clk) begin
    if (srst_i) begin
      r_valid   <= 1'b0;
      r_sop     <= 1'b0;
      r_eop     <= 1'b0;
      r_data    <= '0;
      r_empty   <= '0;
      r_channel <= '0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_sop     <= ast_startofpacket_i[r_grant];
      r_eop     <= ast_endofpacket_i[r_grant];
      r_data    <= w_data[r_grant];
      r_empty   <= w_empty[r_grant];
      r_channel <= CHANNEL_W'(r_grant);
    end else if (w_load) begin
      r_valid   <= 1'b0;
    end
  end

  assign ast_valid_o         = r_valid;
  assign ast_startofpacket_o = r_sop;
  assign ast_endofpacket_o   = r_eop;
  assign ast_data_o          = r_data;
  assign ast_empty_o         = r_empty;
  assign ast_channel_o       = r_channel;

endmodule

// File: tb/tb_ast_packet_arbiter.sv
// Bench for ast_packet_arbiter: packet-level sources, a rule-level reference
// model checked every cycle, and directed scenarios with literal expectations.
module tb_ast_packet_arbiter;
  localparam int N = 4, DW = 64, EW = 3, CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 srst;
  logic [N-1:0]         v_val, v_sop, v_eop;
  logic [N-1:0][DW-1:0] v_dat;
  logic [N-1:0][EW-1:0] v_emp;
  logic                 ds_rdy;
  logic [N-1:0]         ast_ready_o;
  logic [DW-1:0]        ast_data_o;
  logic                 ast_startofpacket_o, ast_endofpacket_o, ast_valid_o;
  logic [EW-1:0]        ast_empty_o;
  logic [CW-1:0]        ast_channel_o;

  ast_packet_arbiter #(.N_REQ(N), .DATA_W(DW), .EMPTY_W(EW), .CHANNEL_W(CW)) dut (
    .clk(clk), .srst_i(srst),
    .ast_data_i(v_dat), .ast_startofpacket_i(v_sop), .ast_endofpacket_i(v_eop),
    .ast_valid_i(v_val), .ast_empty_i(v_emp), .ast_ready_o(ast_ready_o),
    .ast_data_o(ast_data_o), .ast_startofpacket_o(ast_startofpacket_o),
    .ast_endofpacket_o(ast_endofpacket_o), .ast_valid_o(ast_valid_o),
    .ast_empty_o(ast_empty_o), .ast_channel_o(ast_channel_o), .ast_ready_i(ds_rdy)
  );

  int errors = 0, checks = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  typedef struct {
    logic [3:0]  ch;
    logic [63:0] data;
    logic        sop, eop;
    logic [2:0]  emp;
    int          cyc;
  } obeat_t;
  obeat_t out_log[$];

  logic [N-1:0] rdy_hist [256];
  logic         vld_hist [256];
  logic [N-1:0] src_acc;

  // Reference model: owner of the stream (or none), round-robin pointer and
  // the beat sitting in the output stage.
  bit          m_busy, m_ov;
  int          m_grant, m_last;
  logic [63:0] m_dat;
  logic        m_sop, m_eop;
  logic [2:0]  m_emp;
  logic [3:0]  m_ch;
  logic [N-1:0] exp_rdy;

  task automatic model_reset();
    m_busy = 0; m_ov = 0; m_grant = 0; m_last = N - 1;
    m_dat = '0; m_sop = 0; m_eop = 0; m_emp = '0; m_ch = '0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      cyc++;
      exp_rdy = '0;
      if (m_busy && (!m_ov || ds_rdy)) exp_rdy[m_grant] = 1'b1;
      rdy_hist[cyc & 255] = ast_ready_o;
      vld_hist[cyc & 255] = ast_valid_o;
      src_acc = ast_ready_o & v_val;
      if (chk_en) begin
        chk("ready_o", ast_ready_o, exp_rdy);
        chk("valid_o", ast_valid_o, m_ov);
        chk("out_fields",
            {ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_channel_o, ast_data_o},
            {m_sop, m_eop, m_emp, m_ch, m_dat});
        if (ast_valid_o && ds_rdy)
          out_log.push_back('{ch: ast_channel_o, data: ast_data_o, sop: ast_startofpacket_o,
                              eop: ast_endofpacket_o, emp: ast_empty_o, cyc: cyc});
      end
      if (srst) model_reset();
      else if (!m_busy) begin
        if (ds_rdy) m_ov = 0;
        for (int k = 1; k <= N; k++) begin
          int j;
          j = (m_last + k) % N;
          if (v_val[j] && v_sop[j]) begin
            m_busy = 1; m_grant = j; m_last = j;
            break;
          end
        end
      end else if (exp_rdy != '0 && v_val[m_grant]) begin
        m_ov = 1; m_dat = v_dat[m_grant]; m_sop = v_sop[m_grant];
        m_eop = v_eop[m_grant]; m_emp = v_emp[m_grant]; m_ch = 4'(m_grant);
        if (v_eop[m_grant]) m_busy = 0;
      end else if (exp_rdy != '0) m_ov = 0;
    end
  end

  // Packet sources: each holds a queue of (length, empty) packets.
  bit src_act[N];
  int src_len[N], src_beat[N], src_np[N], src_emp[N];
  int q_len[N][$];
  int q_emp[N][$];

  task automatic clear_src();
    v_val = '0; v_sop = '0; v_eop = '0; v_dat = '0; v_emp = '0;
    for (int i = 0; i < N; i++) begin
      src_act[i] = 0; src_np[i] = 0; src_beat[i] = 0;
      q_len[i].delete(); q_emp[i].delete();
    end
  endtask

  task automatic step_src(input bit rnd);
    for (int i = 0; i < N; i++) begin
      if (v_val[i] && src_acc[i]) begin
        if (v_eop[i]) begin src_act[i] = 0; src_np[i]++; end
        else src_beat[i]++;
        v_val[i] = 1'b0;
      end
      if (!v_val[i]) begin
        if (!src_act[i] && q_len[i].size() > 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
          src_act[i] = 1; src_beat[i] = 0;
          src_len[i] = q_len[i].pop_front(); src_emp[i] = q_emp[i].pop_front();
        end
        if (src_act[i] && (!rnd || $urandom_range(0, 3) != 0)) begin
          v_val[i] = 1'b1;
          v_sop[i] = (src_beat[i] == 0);
          v_eop[i] = (src_beat[i] == src_len[i] - 1);
          v_emp[i] = v_eop[i] ? 3'(src_emp[i]) : 3'(src_beat[i]);
          v_dat[i] = {8'(i), 16'(src_np[i]), 8'(src_beat[i]), rnd ? 32'($urandom) : 32'h0};
        end
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin @(posedge clk); #1; step_src(0); end
  endtask

  task automatic do_reset();
    @(posedge clk); #1; srst = 1; ds_rdy = 1; clear_src(); out_log.delete();
    @(posedge clk); #1; srst = 0;
  endtask

  task automatic push(input int i, input int len, input int emp);
    q_len[i].push_back(len); q_emp[i].push_back(emp);
  endtask

  int t0, t1, tot, bound;
  obeat_t e;

  initial begin
    srst = 1; ds_rdy = 1; clear_src();
    repeat (2) @(posedge clk);
    #1 srst = 0; chk_en = 1;
    chk("reset_outputs", {ast_valid_o, ast_startofpacket_o, ast_endofpacket_o, ast_empty_o,
                          ast_channel_o, ast_data_o, ast_ready_o}, '0);

    // Single 3-beat packet from requester 2.
    do_reset(); push(2, 3, 5); step_src(0); t0 = cyc + 1; run(8);
    chk("t1_count", out_log.size(), 3);
    chk("t1_rdy_c0", rdy_hist[t0 & 255], 4'b0000);
    for (int c = 1; c <= 3; c++) chk("t1_rdy_c1to3", rdy_hist[(t0 + c) & 255], 4'b0100);
    chk("t1_rdy_c4", rdy_hist[(t0 + 4) & 255], 4'b0000);
    if (out_log.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        e = out_log[k];
        chk("t1_cycle", e.cyc, t0 + 2 + k);
        chk("t1_chan", e.ch, 4'd2);
        chk("t1_sop", e.sop, k == 0);
        chk("t1_eop", e.eop, k == 2);
      end
      e = out_log[0]; chk("t1_d0", e.data, 64'h0200000000000000);
      e = out_log[2]; chk("t1_d2", e.data, 64'h0200000200000000);
      chk("t1_empty", e.emp, 3'd5);
    end

    // Contention between requesters 0 and 1.
    do_reset(); push(0, 2, 1); push(1, 2, 2); step_src(0); t0 = cyc + 1; run(12);
    chk("t2_count", out_log.size(), 4);
    if (out_log.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        e = out_log[k];
        chk("t2_chan", e.ch, (k < 2) ? 4'd0 : 4'd1);
      end
      e = out_log[2]; chk("t2_gap", e.cyc, t0 + 5);
    end

    // Backpressure on beat 2 of a 4-beat packet.
    do_reset(); push(1, 4, 0); step_src(0); t0 = cyc + 1;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      ds_rdy = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
      step_src(0);
    end
    chk("t3_count", out_log.size(), 4);
    chk("t3_stall_rdy", rdy_hist[(t0 + 4) & 255], 4'b0000);
    chk("t3_stall_vld", vld_hist[(t0 + 4) & 255], 1'b1);
    if (out_log.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        e = out_log[k];
        chk("t3_order", e.data[39:32], 8'(k));
      end
      e = out_log[1]; chk("t3_release", e.cyc, t0 + 6);
    end

    // Round-robin rotation with single-beat packets.
    do_reset();
    for (int i = 0; i < N; i++) repeat (3) push(i, 1, i);
    step_src(0); t0 = cyc + 1; run(30);
    chk("t4_count", out_log.size(), 12);
    if (out_log.size() == 12) begin
      for (int k = 0; k < 12; k++) begin
        e = out_log[k];
        chk("t4_chan", e.ch, 4'(k % 4));
        chk("t4_cycle", e.cyc, t0 + 2 + 2 * k);
      end
    end

    // Valid without SOP is never granted.
    do_reset();
    v_val[3] = 1; v_sop[3] = 0; v_eop[3] = 0; v_dat[3] = 64'h33; t0 = cyc + 1;
    repeat (5) begin @(posedge clk); #1; end
    for (int c = 0; c < 5; c++) begin
      chk("t5_no_rdy", rdy_hist[(t0 + c) & 255], 4'b0000);
      chk("t5_no_vld", vld_hist[(t0 + c) & 255], 1'b0);
    end
    v_sop[3] = 1; v_eop[3] = 1; t1 = cyc + 1;
    @(posedge clk); #1;
    @(posedge clk); #1; v_val[3] = 0;
    run(3);
    chk("t5_grant", rdy_hist[(t1 + 1) & 255], 4'b1000);
    chk("t5_out", out_log.size(), 1);

    // Reset in the middle of a packet from requester 1.
    do_reset(); push(1, 4, 0); step_src(0); t0 = cyc + 1; run(2);
    srst = 1; clear_src();
    @(posedge clk); #1; srst = 0;
    chk("t6_vld_before", vld_hist[(t0 + 2) & 255], 1'b1);
    chk("t6_outputs_zero", {ast_valid_o, ast_startofpacket_o, ast_endofpacket_o, ast_empty_o,
                            ast_channel_o, ast_data_o, ast_ready_o}, '0);
    out_log.delete(); push(1, 2, 0); push(0, 2, 0); step_src(0); run(12);
    chk("t6_count", out_log.size(), 4);
    if (out_log.size() == 4) begin
      e = out_log[0]; chk("t6_first", e.ch, 4'd0);
      e = out_log[2]; chk("t6_second", e.ch, 4'd1);
    end

    // Random traffic against the model.
    do_reset(); tot = 0;
    for (int i = 0; i < N; i++)
      repeat (40) begin
        int l;
        l = $urandom_range(1, 4); tot += l;
        push(i, l, $urandom_range(0, 7));
      end
    step_src(1); bound = 0;
    while (bound < 20000) begin
      bit busy;
      @(posedge clk); #1;
      ds_rdy = ($urandom_range(0, 3) != 0);
      step_src(1);
      busy = (v_val != '0);
      for (int i = 0; i < N; i++) if (src_act[i] || q_len[i].size() > 0) busy = 1;
      if (!busy) break;
      bound++;
    end
    if (bound >= 20000) chk("rand_timeout", bound, 0);
    ds_rdy = 1; run(6);
    chk("rand_beats", out_log.size(), tot);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
